enc8to3_seq: RTL



---
 rtl/enc8to3_seq_if.sv | 13 +
 rtl/enc8to3_seq.sv | 80 ++++++++
 2 files changed

// File: rtl/enc8to3_seq_if.sv
// Request/grant bundle for the sequential 8-to-3 encoder.
// The slave modport is the encoder. The master modport is the request source and consumer.
interface enc8to3_seq_if;
    logic [7:0] in;
    logic [2:0] out_code;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] pending;
    logic       busy;

    modport slave  (input in, out_ready, output out_code, out_valid, pending, busy);
    modport master (output in, out_ready, input out_code, out_valid, pending, busy);
endinterface

// File: rtl/enc8to3_seq.sv
// Sequential 8-to-3 encoder: merges request pulses into a pending set and emits
// one 3-bit code per request over valid/ready, fixed-priority or round-robin.
module enc8to3_seq #(
    parameter bit RR_MODE = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    enc8to3_seq_if.slave  bus
);
    typedef enum logic {IDLE, HOLD} state_e;

    state_e     state_q, state_d;
    logic [2:0] code_q, code_d;
    logic [2:0] last_q, last_d;
    logic [7:0] pend_q, pend_d;
    logic [7:0] cand, sel_oh;
    logic [2:0] sel;
    logic       found;

    assign cand = pend_q | bus.in;

    always_comb begin
        sel   = 3'd0;
        found = 1'b0;
        if (RR_MODE) begin
            for (int k = 1; k <= 8; k++) begin
                if (!found && cand[last_q + 3'(k)]) begin
                    sel   = last_q + 3'(k);
                    found = 1'b1;
                end
            end
        end else begin
            for (int k = 7; k >= 0; k--) begin
                if (cand[k]) sel = 3'(k);
            end
        end
    end

    assign sel_oh = 8'd1 << sel;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            code_q  <= 3'o0;
            last_q  <= 3'o7;
            pend_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            last_q  <= last_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        last_d  = last_q;
        pend_d  = pend_q;
        if (state_q == HOLD && !bus.out_ready) begin
            pend_d = pend_q | bus.in;
        end else if (cand != 8'h00) begin
            state_d = HOLD;
            code_d  = sel;
            last_d  = sel;
            // A fresh pulse on an already-pending bit being granted survives the clear.
            pend_d  = (cand & ~sel_oh) | (bus.in & pend_q & sel_oh);
        end else begin
            state_d = IDLE;
            pend_d  = 8'h00;
        end
    end

    always_comb begin
        bus.out_valid = (state_q == HOLD);
        bus.out_code  = code_q;
        bus.pending   = pend_q;
        bus.busy      = (pend_q != 8'h00) || (state_q == HOLD);
    end
endmodule
